// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel-rate divider, h/v counters, sync/blank,
// line/frame strobes, frame counter and a look-ahead fetch coordinate for prefetching.
module vga_timing_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int LOOKAHEAD = 2,
    parameter int CNT_W     = 11,
    parameter int FRAME_W   = 8
) (
    input  logic               clock,
    input  logic               clear_n,
    input  logic               run,
    output logic               pixTick,
    output logic               hSync,
    output logic               vSync,
    output logic               bright,
    output logic [CNT_W-1:0]   hCount,
    output logic [CNT_W-1:0]   vCount,
    output logic               lineStart,
    output logic               frameStart,
    output logic [FRAME_W-1:0] frameCount,
    output logic               reqValid,
    output logic [CNT_W-1:0]   reqX,
    output logic [CNT_W-1:0]   reqY
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [CNT_W-1:0] LA_INIT  = CNT_W'(LOOKAHEAD);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("CLK_DIV must be at least 1");
    end
    if ((H_TOTAL - 1) >= (1 << CNT_W) || (V_TOTAL - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for H_TOTAL-1 / V_TOTAL-1");
    end
    if (LOOKAHEAD < 0 || LOOKAHEAD >= H_TOTAL) begin : g_bad_lookahead
        $error("LOOKAHEAD must be in 0..H_TOTAL-1");
    end

    logic [DIV_W-1:0]   r_div_cnt;
    logic [CNT_W-1:0]   r_h, r_v, r_ha, r_va;
    logic [FRAME_W-1:0] r_frame;

    logic               w_tick;
    logic               w_h_last, w_v_last, w_ha_last, w_va_last;
    logic [CNT_W-1:0]   w_h_nxt, w_v_nxt, w_ha_nxt, w_va_nxt;
    logic               w_hs_act, w_vs_act;

    // Next-position arithmetic shared by the display and look-ahead counter pairs.
    always_comb begin
        w_tick    = run && (r_div_cnt == {DIV_W{1'b0}});
        w_h_last  = (r_h == H_LAST);
        w_v_last  = (r_v == V_LAST);
        w_ha_last = (r_ha == H_LAST);
        w_va_last = (r_va == V_LAST);
        w_h_nxt   = w_h_last ? {CNT_W{1'b0}} : r_h + CNT_W'(1);
        w_ha_nxt  = w_ha_last ? {CNT_W{1'b0}} : r_ha + CNT_W'(1);
        if (w_h_last) begin
            w_v_nxt = w_v_last ? {CNT_W{1'b0}} : r_v + CNT_W'(1);
        end else begin
            w_v_nxt = r_v;
        end
        if (w_ha_last) begin
            w_va_nxt = w_va_last ? {CNT_W{1'b0}} : r_va + CNT_W'(1);
        end else begin
            w_va_nxt = r_va;
        end
        w_hs_act = (r_h >= HS_FIRST) && (r_h <= HS_LAST);
        w_vs_act = (r_v >= VS_FIRST) && (r_v <= VS_LAST);
    end

    // Divider, position counters and frame counter.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            r_div_cnt <= {DIV_W{1'b0}};
            r_h       <= {CNT_W{1'b0}};
            r_v       <= {CNT_W{1'b0}};
            r_ha      <= LA_INIT;
            r_va      <= {CNT_W{1'b0}};
            r_frame   <= {FRAME_W{1'b0}};
        end else begin
            if (run) begin
                r_div_cnt <= (r_div_cnt == DIV_LAST) ? {DIV_W{1'b0}} : r_div_cnt + DIV_W'(1);
            end
            if (w_tick) begin
                r_h  <= w_h_nxt;
                r_v  <= w_v_nxt;
                r_ha <= w_ha_nxt;
                r_va <= w_va_nxt;
                if (w_h_last && w_v_last) begin
                    r_frame <= r_frame + FRAME_W'(1);
                end
            end
        end
    end

    // Output stage: every output sampled from the same pre-update counter state.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            pixTick    <= 1'b0;
            hSync      <= ~HSYNC_POL;
            vSync      <= ~VSYNC_POL;
            bright     <= 1'b0;
            hCount     <= {CNT_W{1'b0}};
            vCount     <= {CNT_W{1'b0}};
            lineStart  <= 1'b0;
            frameStart <= 1'b0;
            frameCount <= {FRAME_W{1'b0}};
            reqValid   <= 1'b0;
            reqX       <= {CNT_W{1'b0}};
            reqY       <= {CNT_W{1'b0}};
        end else begin
            pixTick    <= w_tick;
            hSync      <= w_hs_act ? HSYNC_POL : ~HSYNC_POL;
            vSync      <= w_vs_act ? VSYNC_POL : ~VSYNC_POL;
            bright     <= (r_h < H_VIS) && (r_v < V_VIS);
            hCount     <= r_h;
            vCount     <= r_v;
            lineStart  <= w_tick && (r_h == {CNT_W{1'b0}});
            frameStart <= w_tick && (r_h == {CNT_W{1'b0}}) && (r_v == {CNT_W{1'b0}});
            frameCount <= r_frame;
            reqValid   <= (r_ha < H_VIS) && (r_va < V_VIS);
            reqX       <= r_ha;
            reqY       <= r_va;
        end
    end

endmodule
